// File: rtl/rng_range_sampler.sv
// Unbiased bounded-integer draw from a 32-bit uniform stream using bitmask rejection sampling.
// Request handshake at N, first word consumed from N+1, sample valid the cycle after acceptance.
module rng_range_sampler #(
    parameter int W       = 32,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [W-1:0]       req_bound,
    input  logic [31:0]        rnd,
    input  logic               rnd_valid,
    output logic               rnd_ready,
    output logic               smp_valid,
    input  logic               smp_ready,
    output logic [W-1:0]       smp_data,
    output logic [COUNT_W-1:0] rej_count,
    input  logic               clr_stats,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, DRAW, HOLD} state_t;

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] bound_q;
    logic [W-1:0] mask_q;
    logic [W-1:0] cand;
    logic         rnd_take;
    logic         accept;
    logic         reject;
    logic         req_take;

    // Smear the MSB of x into every lower bit: smallest 2^k-1 covering x.
    // bound-1 wraps to all ones for bound==0 and is 0 for bound==1, so both
    // special cases fall out of the same expression.
    function automatic logic [W-1:0] smear(input logic [W-1:0] x);
        logic [W-1:0] m;
        m = x;
        for (int i = 1; i < W; i = i * 2) begin
            m = m | (m >> i);
        end
        return m;
    endfunction

    assign req_take = (state == IDLE) && req_valid;
    assign rnd_take = (state == DRAW) && rnd_valid;
    assign cand     = rnd[W-1:0] & mask_q;
    assign accept   = rnd_take && ((bound_q == '0) || (cand < bound_q));
    assign reject   = rnd_take && !accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = DRAW;
            DRAW:    if (accept)    state_nxt = HOLD;
            HOLD:    if (smp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake readies depend on state only, never on inputs.
    always_comb begin
        req_ready = 1'b0;
        rnd_ready = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: req_ready = 1'b1;
            DRAW: begin
                rnd_ready = 1'b1;
                busy      = 1'b1;
            end
            HOLD: busy = 1'b1;
            default: req_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bound_q <= '0;
            mask_q  <= '0;
        end else if (req_take) begin
            bound_q <= req_bound;
            mask_q  <= smear(req_bound - 1'b1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_valid <= 1'b0;
            smp_data  <= '0;
        end else if (accept) begin
            smp_valid <= 1'b1;
            smp_data  <= cand;
        end else if ((state == HOLD) && smp_ready) begin
            smp_valid <= 1'b0;
        end
    end

    // Clear takes priority over a simultaneous rejection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rej_count <= '0;
        end else if (clr_stats) begin
            rej_count <= '0;
        end else if (reject && (rej_count != '1)) begin
            rej_count <= rej_count + 1'b1;
        end
    end

endmodule
